bch_syndrome_sched: RTL and testbench
=====================================

BCH_SYNDROME_SCHED -- requirements
Module: bch_syndrome_sched

Interface
REQ-001 Parameter BITS, default 1: codeword bits per beat; SHALL equal the attached syndrome engine's BITS.
REQ-002 Parameter CODE_BITS, default 15: codeword length in bits; beats per frame NB = ceil(CODE_BITS/BITS).
REQ-003 Parameter SYN_W, default 12: syndrome bus width of the attached engine.
REQ-004 Port clk, input, 1: single clock, rising edge.
REQ-005 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-006 Ports req[1:0], input, 2: requester i has a frame pending; held until its last beat is accepted.
REQ-007 Ports in_data0, in_data1, input, BITS each: per-requester beat data.
REQ-008 Ports in_valid[1:0], input, 2: per-requester beat valid.
REQ-009 Port in_ready[1:0], output, 2: beat accepted when in_valid[i] & in_ready[i].
REQ-010 Ports eng_start, eng_ce (output, 1), eng_data (output, BITS): drive the syndrome engine.
REQ-011 Ports eng_ready, eng_done (input, 1), eng_syn (input, SYN_W): engine status and result.
REQ-012 Ports out_valid (output, 1), out_id (output, 1), out_syn (output, SYN_W), out_ready (input, 1): result handshake.

Function
REQ-013 States: IDLE, FEED, WAIT, OUT; 2-bit encoding.
REQ-014 IDLE: when any req bit is set and eng_ready=1, grant one requester, load beat counter to 0, go to FEED next cycle; otherwise stay.
REQ-015 Arbitration: round-robin; priority pointer points at the requester not most recently granted; after reset requester 0 has priority; both requesting grants the pointer holder.
REQ-016 FEED: in_ready[g]=1 only for the granted requester g; the other in_ready SHALL be 0.
REQ-017 FEED: eng_ce = in_valid[g]; eng_data = in_data of g (combinational pass-through); eng_start = eng_ce when counter = 0.
REQ-018 Counter increments on each accepted beat; on the accepted beat at counter = NB-1 go to WAIT; in_valid gaps stall without advancing.
REQ-019 WAIT: eng_ce=0, in_ready=0; on eng_done=1 capture eng_syn into out_syn and g into out_id, go to OUT.
REQ-020 OUT: out_valid=1; out_syn and out_id stable; on out_valid & out_ready go to IDLE and flip the priority pointer away from g.
REQ-021 In OUT, no new grant; a new frame starts no earlier than the cycle after out_ready handshake (IDLE cycle mandatory).
REQ-022 eng_done outside WAIT SHALL be ignored.
REQ-023 req[g] dropping mid-FEED SHALL NOT abort the frame; the frame completes on in_valid beats.
REQ-024 Counter width SHALL be ceil(log2(NB+1)), minimum 1; no wrap beyond NB-1.

Reset
REQ-025 rst_n=0 asynchronously forces: state IDLE, counter 0, pointer to requester 0, out_valid 0, out_id 0, out_syn 0, in_ready 0, eng_start 0, eng_ce 0.
REQ-026 Reset mid-frame SHALL abandon the frame without completion; after release the first action is a normal IDLE arbitration.
REQ-027 All registers SHALL use the asynchronous active-low reset; no synchronous reset term.

Structure
REQ-028 State encoding localparams and the NB/counter-width function SHALL live in the shared bch package/include alongside bch_params.
REQ-029 One sub-module is natural: rr_arb2 (two-way round-robin arbiter, grant + pointer update); the datapath mux stays in the top module.
REQ-030 The engine (bch_syndrome) SHALL be external; this block contains no syndrome arithmetic.

Verification
REQ-031 Single frame: req=01, NB beats back-to-back, eng_done after 3 cycles with eng_syn=0xABC -> out_valid, out_id=0, out_syn=0xABC; eng_start high on beat 0 only.
REQ-032 Contention: req=11 from reset -> requester 0 served first, then 1; repeat -> order alternates 0,1,0,1.
REQ-033 Backpressure: in_valid toggling 1,0,1 during FEED -> eng_ce follows in_valid, exactly NB eng_ce pulses per frame.
REQ-034 Output stall: out_ready=0 for 10 cycles -> out_valid/out_syn stable, no in_ready asserted, no new grant.
REQ-035 Reset mid-FEED at beat 2 -> all outputs at reset values immediately; next frame counts from 0 with eng_start on its first beat.
REQ-036 eng_ready=0 with req=01 -> stays IDLE, in_ready=00; grant the cycle after eng_ready rises.

Source files
------------

// File: rtl/bch_syndrome_sched_pkg.sv
// Shared definitions for the BCH syndrome scheduler: FSM encoding and
// beat-count / counter-width helpers.
package bch_syndrome_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FEED = 2'd1,
        ST_WAIT = 2'd2,
        ST_OUT  = 2'd3
    } state_t;

    // Beats per frame: ceil(code_bits / bits).
    function automatic int nb_of(input int code_bits, input int bits);
        return (code_bits + bits - 1) / bits;
    endfunction

    // Counter width: ceil(log2(nb + 1)), never below 1.
    function automatic int cnt_w_of(input int nb);
        int w;
        w = 1;
        while ((1 << w) < (nb + 1)) w++;
        return w;
    endfunction

endpackage

// File: rtl/bch_syndrome_sched_rr_arb2.sv
// Two-way round-robin arbiter. The pointer names the requester that wins a
// tie; it moves away from the served requester when its frame retires.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       upd,
    input  logic       upd_id,
    output logic       gnt_vld,
    output logic       gnt_id
);

    logic ptr_q;

    // Tie goes to the pointer holder, otherwise the lone requester wins.
    always_comb begin
        gnt_vld = |req;
        gnt_id  = (req[0] & req[1]) ? ptr_q : req[1];
    end

    // Pointer flips away from the requester whose result was just taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   ptr_q <= 1'b0;
        else if (upd) ptr_q <= ~upd_id;
    end

endmodule

// File: rtl/bch_syndrome_sched.sv
// Shares one external BCH syndrome engine between two requesters: grants a
// frame, streams its beats into the engine, waits for the syndrome and holds
// it on a valid/ready output until taken.
module bch_syndrome_sched
    import bch_syndrome_sched_pkg::*;
#(
    parameter int BITS      = 1,
    parameter int CODE_BITS = 15,
    parameter int SYN_W     = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req,
    input  logic [BITS-1:0]  in_data0,
    input  logic [BITS-1:0]  in_data1,
    input  logic [1:0]       in_valid,
    output logic [1:0]       in_ready,
    output logic             eng_start,
    output logic             eng_ce,
    output logic [BITS-1:0]  eng_data,
    input  logic             eng_ready,
    input  logic             eng_done,
    input  logic [SYN_W-1:0] eng_syn,
    output logic             out_valid,
    output logic             out_id,
    output logic [SYN_W-1:0] out_syn,
    input  logic             out_ready
);

    localparam int NB = nb_of(CODE_BITS, BITS);
    localparam int CW = cnt_w_of(NB);
    localparam logic [CW-1:0] LAST = CW'(NB - 1);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q;
    logic             gnt_q;
    logic             out_id_q;
    logic [SYN_W-1:0] out_syn_q;
    logic             arb_vld, arb_id, arb_upd;
    logic             load, acc, cap;

    rr_arb2 u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .upd     (arb_upd),
        .upd_id  (gnt_q),
        .gnt_vld (arb_vld),
        .gnt_id  (arb_id)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next state, handshakes and the engine-side data mux.
    always_comb begin
        state_d   = state_q;
        in_ready  = 2'b00;
        eng_ce    = 1'b0;
        eng_start = 1'b0;
        eng_data  = '0;
        out_valid = 1'b0;
        arb_upd   = 1'b0;
        load      = 1'b0;
        acc       = 1'b0;
        cap       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (arb_vld && eng_ready) begin
                    load    = 1'b1;
                    state_d = ST_FEED;
                end
            end
            ST_FEED: begin
                // req may drop here; the frame still runs to its last beat.
                in_ready[gnt_q] = 1'b1;
                eng_ce          = in_valid[gnt_q];
                eng_data        = gnt_q ? in_data1 : in_data0;
                eng_start       = eng_ce && (cnt_q == '0);
                acc             = eng_ce;
                if (acc && (cnt_q == LAST)) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (eng_done) begin
                    cap     = 1'b1;
                    state_d = ST_OUT;
                end
            end
            ST_OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    arb_upd = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Beat counter, granted id and captured result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            gnt_q     <= 1'b0;
            out_id_q  <= 1'b0;
            out_syn_q <= '0;
        end else begin
            if (load) begin
                cnt_q <= '0;
                gnt_q <= arb_id;
            end else if (acc && (cnt_q != LAST)) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (cap) begin
                out_syn_q <= eng_syn;
                out_id_q  <= gnt_q;
            end
        end
    end

    assign out_id  = out_id_q;
    assign out_syn = out_syn_q;

endmodule

// File: tb/tb_bch_syndrome_sched.sv
// Randomized bench for bch_syndrome_sched: behavioural requesters, a fake
// syndrome engine that hashes the beats it receives, and a scoreboard fed
// from a round-robin service-order model.
module tb_bch_syndrome_sched;

    localparam int BITS      = 1;
    localparam int CODE_BITS = 15;
    localparam int SYN_W     = 12;
    localparam int NB        = (CODE_BITS + BITS - 1) / BITS;
    localparam int FW        = NB * BITS;

    typedef struct packed {
        logic             id;
        logic [SYN_W-1:0] syn;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             req0 = 1'b0, req1 = 1'b0;
    logic             vld0 = 1'b0, vld1 = 1'b0;
    logic [BITS-1:0]  dat0 = '0, dat1 = '0;
    logic [1:0]       req, in_valid, in_ready;
    logic             eng_start, eng_ce;
    logic [BITS-1:0]  eng_data;
    logic             eng_ready = 1'b0, eng_done = 1'b0;
    logic [SYN_W-1:0] eng_syn = '0;
    logic             out_valid, out_id;
    logic [SYN_W-1:0] out_syn;
    logic             out_ready = 1'b0;

    int     nchk = 0, nerr = 0;
    exp_t   sb[$];
    int     eng_nb = 0, eng_busy = 0;
    logic [FW-1:0] eng_col = '0;
    bit     hold_ready = 1'b0;
    int     stall = 0;
    bit     ptr = 1'b0;

    assign req      = {req1, req0};
    assign in_valid = {vld1, vld0};

    bch_syndrome_sched #(.BITS(BITS), .CODE_BITS(CODE_BITS), .SYN_W(SYN_W)) dut (
        .clk(clk), .rst_n(rst_n), .req(req),
        .in_data0(dat0), .in_data1(dat1), .in_valid(in_valid), .in_ready(in_ready),
        .eng_start(eng_start), .eng_ce(eng_ce), .eng_data(eng_data),
        .eng_ready(eng_ready), .eng_done(eng_done), .eng_syn(eng_syn),
        .out_valid(out_valid), .out_id(out_id), .out_syn(out_syn), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Stand-in syndrome: any fixed hash of the frame bits will do.
    function automatic logic [SYN_W-1:0] syn_of(input logic [FW-1:0] f);
        logic [31:0] x;
        x = (32'(f) * 32'd40503) ^ 32'h5A5;
        return x[23:12] ^ x[11:0];
    endfunction

    task automatic set_in(input int i, input logic r, input logic v, input logic [BITS-1:0] d);
        if (i == 0) begin req0 = r; vld0 = v; dat0 = d; end
        else        begin req1 = r; vld1 = v; dat1 = d; end
    endtask

    // One requester: hold req, offer beats with random gaps until all accepted.
    task automatic drive(input int i, input logic [FW-1:0] fr);
        int k, guard;
        logic v, acc;
        k = 0; guard = 0;
        @(negedge clk);
        while (k < NB) begin
            v = ($urandom_range(0, 3) != 0);
            set_in(i, 1'b1, v, fr[k*BITS +: BITS]);
            #1 acc = v && in_ready[i];
            @(negedge clk);
            if (acc) k++;
            guard++;
            if (guard > 3000) begin
                chk("drive_timeout", 32'(k), 32'(NB));
                break;
            end
        end
        set_in(i, 1'b0, 1'b0, '0);
    endtask

    // Engine readiness: random unless a test pins it low.
    initial forever begin
        @(negedge clk);
        eng_ready = hold_ready ? 1'b0 : ($urandom_range(0, 4) != 0);
    end

    // Result sink: random out_ready with occasional 10-cycle stalls.
    initial forever begin
        @(negedge clk);
        if (stall > 0) begin
            out_ready = 1'b0;
            stall--;
        end else if ($urandom_range(0, 9) == 0) begin
            out_ready = 1'b0;
            stall = 9;
        end else begin
            out_ready = ($urandom_range(0, 2) != 0);
        end
    end

    // Fake engine: gathers beats, answers 1..4 cycles after the last one,
    // and throws stray done pulses with junk syndromes while not busy.
    initial forever begin
        @(negedge clk);
        #3;
        eng_done = 1'b0;
        eng_syn  = SYN_W'($urandom);
        if (!rst_n) begin
            eng_nb = 0; eng_busy = 0; eng_col = '0;
        end else if (eng_busy > 0) begin
            chk("ce_while_waiting", 32'(eng_ce), 32'd0);
            eng_busy--;
            if (eng_busy == 0) begin
                eng_done = 1'b1;
                eng_syn  = syn_of(eng_col);
                eng_nb   = 0;
                eng_col  = '0;
            end
        end else begin
            if (eng_ce) begin
                chk("eng_start", 32'(eng_start), 32'(eng_nb == 0));
                eng_col[eng_nb*BITS +: BITS] = eng_data;
                eng_nb++;
                if (eng_nb == NB) eng_busy = $urandom_range(1, 4);
            end
            if (eng_busy == 0 && $urandom_range(0, 7) == 0) eng_done = 1'b1;
        end
    end

    // Output monitor: scoreboard pop on handshake, stability and quiet inputs while held.
    initial begin
        exp_t e;
        bit have_prev;
        logic [SYN_W-1:0] p_syn;
        logic p_id;
        have_prev = 1'b0; p_syn = '0; p_id = 1'b0;
        forever begin
            @(negedge clk);
            #3;
            if (!rst_n || !out_valid) begin
                have_prev = 1'b0;
            end else begin
                chk("in_ready_during_out", 32'(in_ready), 32'd0);
                if (have_prev) begin
                    chk("out_syn_stable", 32'(out_syn), 32'(p_syn));
                    chk("out_id_stable", 32'(out_id), 32'(p_id));
                end
                if (out_ready) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_output", 32'(out_syn), 32'hFFFF_FFFF);
                    end else begin
                        e = sb.pop_front();
                        chk("out_id", 32'(out_id), 32'(e.id));
                        chk("out_syn", 32'(out_syn), 32'(e.syn));
                    end
                    have_prev = 1'b0;
                end else begin
                    have_prev = 1'b1; p_syn = out_syn; p_id = out_id;
                end
            end
        end
    end

    task automatic drain();
        int guard;
        guard = 0;
        while (sb.size() != 0 && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        chk("drain_left", 32'(sb.size()), 32'd0);
    endtask

    // Predict the service order of one round and push expected results.
    task automatic plan(input logic [1:0] pat, input logic [FW-1:0] f0, input logic [FW-1:0] f1);
        bit first;
        if (pat == 2'b11) begin
            first = ptr;
            sb.push_back('{id: first,  syn: syn_of(first  ? f1 : f0)});
            sb.push_back('{id: ~first, syn: syn_of(!first ? f1 : f0)});
            ptr = first;
        end else begin
            first = pat[1];
            sb.push_back('{id: first, syn: syn_of(first ? f1 : f0)});
            ptr = ~first;
        end
    endtask

    initial begin
        logic [FW-1:0] f0, f1;
        logic [1:0] pat;
        int guard;

        // Reset values
        #2;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_eng_ce", 32'(eng_ce), 32'd0);
        chk("rst_eng_start", 32'(eng_start), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_id", 32'(out_id), 32'd0);
        chk("rst_out_syn", 32'(out_syn), 32'd0);
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;

        // Reset in the middle of a frame, with two beats taken
        @(negedge clk);
        req0 = 1'b1; vld0 = 1'b1; dat0 = 1'b1;
        guard = 0;
        do begin
            @(negedge clk); #4; guard++;
        end while (eng_nb < 2 && guard < 200);
        chk("midframe_beats", 32'(eng_nb), 32'd2);
        @(posedge clk);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
        chk("mid_rst_eng_ce", 32'(eng_ce), 32'd0);
        chk("mid_rst_eng_start", 32'(eng_start), 32'd0);
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        req0 = 1'b0; vld0 = 1'b0; dat0 = '0;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;

        // Engine not ready: no grant until it rises, then grant next cycle
        @(negedge clk);
        #1 hold_ready = 1'b1; eng_ready = 1'b0;
        f0 = FW'($urandom);
        plan(2'b01, f0, '0);
        fork
            drive(0, f0);
            begin
                repeat (5) begin
                    @(negedge clk); #3;
                    chk("idle_no_grant", 32'(in_ready), 32'd0);
                end
                @(negedge clk);
                #1 eng_ready = 1'b1; hold_ready = 1'b0;
                @(negedge clk); #3;
                chk("grant_after_ready", 32'(in_ready), 32'd1);
            end
        join
        drain();

        // Random rounds; the first few are full contention
        for (int r = 0; r < 40; r++) begin
            pat = (r < 4) ? 2'b11 : 2'($urandom_range(1, 3));
            f0 = FW'($urandom);
            f1 = FW'($urandom);
            plan(pat, f0, f1);
            fork
                begin if (pat[0]) drive(0, f0); end
                begin if (pat[1]) drive(1, f1); end
            join
            drain();
        end

        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
